fetch_unit: RTL

- Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's PC input.
- The memory returns its word one clock later (registered read at posedge). The fetch unit pairs each returned word with the PC that produced it and presents both, with a valid flag, to decode.
- Handles boot, sequential advance, decode stall, taken-branch redirect with squash, and a sticky halt.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from decode/execute, the instruction-memory link,
// and the instruction presented to decode.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                in_stall;
    logic                in_branch_taken;
    logic [PC_WIDTH-1:0] in_branch_target;
    logic                in_halt;
    logic [31:0]         in_imem_inst;
    logic [PC_WIDTH-1:0] out_imem_pc;
    logic [PC_WIDTH-1:0] out_pc;
    logic [31:0]         out_inst;
    logic                out_valid;
    logic [1:0]          out_state;
    logic [31:0]         out_fetch_count;

    modport master (
        input  in_stall, in_branch_taken, in_branch_target, in_halt, in_imem_inst,
        output out_imem_pc, out_pc, out_inst, out_valid, out_state, out_fetch_count
    );

    modport slave (
        output in_stall, in_branch_taken, in_branch_target, in_halt, in_imem_inst,
        input  out_imem_pc, out_pc, out_inst, out_valid, out_state, out_fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a registered-read instruction memory
// and presents each returned word with its PC to decode (boot, stall, branch, halt).
module fetch_unit #(
    parameter int          PC_WIDTH = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_p0, fetch_pc_d;
    logic [PC_WIDTH-1:0] issued_pc_p1, issued_pc_d;
    logic                vld_p1, vld_d;
    logic                held_p1, held_d;
    logic [31:0]         inst_hold_p1, inst_hold_d;
    logic [31:0]         count_q, count_d;

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(PC_STEP);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            fetch_pc_p0  <= PC_WIDTH'(RESET_PC);
            issued_pc_p1 <= PC_WIDTH'(RESET_PC);
            vld_p1       <= 1'b0;
            held_p1      <= 1'b0;
            inst_hold_p1 <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_p0  <= fetch_pc_d;
            issued_pc_p1 <= issued_pc_d;
            vld_p1       <= vld_d;
            held_p1      <= held_d;
            inst_hold_p1 <= inst_hold_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_p0;
        issued_pc_d = issued_pc_p1;
        vld_d       = vld_p1;
        held_d      = held_p1;
        inst_hold_d = inst_hold_p1;
        count_d     = count_q;
        if (state_q == HALT) begin
            state_d = HALT;
        end else if (bus.in_halt) begin
            state_d = HALT;
            vld_d   = 1'b0;
            held_d  = 1'b0;
        end else if (bus.in_branch_taken) begin
            fetch_pc_d = bus.in_branch_target;
            state_d    = BUBBLE;
            vld_d      = 1'b0;
            held_d     = 1'b0;
        end else if (bus.in_stall && vld_p1) begin
            // The memory is already reading fetch_pc (one ahead of issued_pc), so the
            // presented word is latched on the first stalled edge to keep it stable.
            if (!held_p1) begin
                held_d      = 1'b1;
                inst_hold_d = bus.in_imem_inst;
            end
        end else begin
            issued_pc_d = fetch_pc_p0;
            fetch_pc_d  = pc_inc(fetch_pc_p0);
            vld_d       = 1'b1;
            held_d      = 1'b0;
            state_d     = RUN;
            if (vld_p1) count_d = count_q + 32'd1;
        end
    end

    assign bus.out_imem_pc     = fetch_pc_p0;
    assign bus.out_pc          = issued_pc_p1;
    assign bus.out_valid       = vld_p1;
    assign bus.out_state       = state_q;
    assign bus.out_fetch_count = count_q;
    assign bus.out_inst        = !vld_p1 ? 32'd0 : (held_p1 ? inst_hold_p1 : bus.in_imem_inst);

endmodule
